// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - box filter run sequencer with timeout and DONE-only middle RAM read arbitration
module pipeline_sequencer #(
    parameter int WIDTH_BITS     = 8,
    parameter int HEIGHT_BITS    = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic [4:0]             iC,
    output logic [4:0]             oC,
    output logic                   oFilterResetN,
    output logic                   oProcessing,
    input  logic                   iFinished,
    input  logic                   iDispReq,
    input  logic [WIDTH_BITS-1:0]  iDispCol,
    input  logic [HEIGHT_BITS-1:0] iDispRow,
    input  logic                   iHostReq,
    input  logic [WIDTH_BITS-1:0]  iHostCol,
    input  logic [HEIGHT_BITS-1:0] iHostRow,
    output logic [WIDTH_BITS-1:0]  oRdCol,
    output logic [HEIGHT_BITS-1:0] oRdRow,
    output logic                   oDispGrant,
    output logic                   oHostGrant,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oTimeout,
    output logic [23:0]            oRunCycles
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } seqState;

    localparam logic [23:0] TIMEOUT_COUNT = 24'(TIMEOUT_CYCLES);

    seqState     state;
    logic        startPrev;
    logic        startEdge;
    logic        phase;
    logic [23:0] nextCount;

    assign startEdge = iStart & ~startPrev;

    always_comb begin
        nextCount = oRunCycles;
        if (oRunCycles != 24'hFFFFFF) begin
            nextCount = oRunCycles + 24'd1;
        end
    end

    // ARM and DRAIN both last two cycles; phase marks the second one.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            startPrev     <= iStart;
            phase         <= 1'b0;
            oC            <= 5'd0;
            oFilterResetN <= 1'b1;
            oProcessing   <= 1'b0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
            oTimeout      <= 1'b0;
            oRunCycles    <= 24'd0;
        end else begin
            startPrev <= iStart;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (startEdge) begin
                        state         <= ARM;
                        phase         <= 1'b0;
                        oC            <= iC;
                        oTimeout      <= 1'b0;
                        oRunCycles    <= 24'd0;
                        oFilterResetN <= 1'b0;
                        oProcessing   <= 1'b0;
                        oBusy         <= 1'b1;
                        oDone         <= 1'b0;
                    end
                end
                ARM: begin
                    if (phase) begin
                        state         <= RUN;
                        oFilterResetN <= 1'b1;
                        oProcessing   <= 1'b1;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                RUN: begin
                    oRunCycles <= nextCount;
                    // A finish flag seen on the timeout cycle still counts as success.
                    if (iFinished) begin
                        state       <= DRAIN;
                        phase       <= 1'b0;
                        oProcessing <= 1'b0;
                    end else if (nextCount >= TIMEOUT_COUNT) begin
                        state         <= ERROR;
                        oTimeout      <= 1'b1;
                        oProcessing   <= 1'b0;
                        oFilterResetN <= 1'b0;
                        oBusy         <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (phase) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        phase <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Results are only readable once the run has settled; display has priority.
    always_comb begin
        oDispGrant = 1'b0;
        oHostGrant = 1'b0;
        oRdCol     = '0;
        oRdRow     = '0;
        if (state == DONE) begin
            if (iDispReq) begin
                oDispGrant = 1'b1;
                oRdCol     = iDispCol;
                oRdRow     = iDispRow;
            end else if (iHostReq) begin
                oHostGrant = 1'b1;
                oRdCol     = iHostCol;
                oRdRow     = iHostRow;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb/tb_pipeline_sequencer.sv - directed self-checking bench for pipeline_sequencer
module tb_pipeline_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       iStart;
    logic [4:0] iC;
    logic       iFinished;
    logic       iDispReq, iHostReq;
    logic [7:0] iDispCol, iHostCol;
    logic [7:0] iDispRow, iHostRow;

    logic [4:0]  oC, tC;
    logic        oFilterResetN, tFilterResetN;
    logic        oProcessing, tProcessing;
    logic [7:0]  oRdCol, tRdCol, oRdRow, tRdRow;
    logic        oDispGrant, tDispGrant, oHostGrant, tHostGrant;
    logic        oBusy, tBusy, oDone, tDone, oTimeout, tTimeout;
    logic [23:0] oRunCycles, tRunCycles;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    pipeline_sequencer dut (
        .clock(clock), .reset(reset), .iStart(iStart), .iC(iC), .oC(oC),
        .oFilterResetN(oFilterResetN), .oProcessing(oProcessing), .iFinished(iFinished),
        .iDispReq(iDispReq), .iDispCol(iDispCol), .iDispRow(iDispRow),
        .iHostReq(iHostReq), .iHostCol(iHostCol), .iHostRow(iHostRow),
        .oRdCol(oRdCol), .oRdRow(oRdRow), .oDispGrant(oDispGrant), .oHostGrant(oHostGrant),
        .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout), .oRunCycles(oRunCycles)
    );

    pipeline_sequencer #(.TIMEOUT_CYCLES(16)) dutT (
        .clock(clock), .reset(reset), .iStart(iStart), .iC(iC), .oC(tC),
        .oFilterResetN(tFilterResetN), .oProcessing(tProcessing), .iFinished(iFinished),
        .iDispReq(iDispReq), .iDispCol(iDispCol), .iDispRow(iDispRow),
        .iHostReq(iHostReq), .iHostCol(iHostCol), .iHostRow(iHostRow),
        .oRdCol(tRdCol), .oRdRow(tRdRow), .oDispGrant(tDispGrant), .oHostGrant(tHostGrant),
        .oBusy(tBusy), .oDone(tDone), .oTimeout(tTimeout), .oRunCycles(tRunCycles)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; iStart = 1'b0; iC = 5'd0; iFinished = 1'b0;
        iDispReq = 1'b0; iHostReq = 1'b0;
        iDispCol = 8'd0; iDispRow = 8'd0; iHostCol = 8'd0; iHostRow = 8'd0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (oC !== 5'd0) begin errors++; $display("FAIL reset_oC got=%0d exp=0", oC); end
        checks++; if ({oFilterResetN, oProcessing, oBusy, oDone, oTimeout} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got=%b exp=10000", {oFilterResetN, oProcessing, oBusy, oDone, oTimeout}); end
        checks++; if (oRunCycles !== 24'd0) begin errors++; $display("FAIL reset_runcycles got=%0d exp=0", oRunCycles); end
        checks++; if ({oDispGrant, oHostGrant, oRdCol, oRdRow} !== 18'd0) begin
            errors++; $display("FAIL reset_read got=%h exp=0", {oDispGrant, oHostGrant, oRdCol, oRdRow}); end
    endtask

    task automatic test_start();
        iC = 5'd2; iStart = 1'b1;
        step();
        iStart = 1'b0;
        checks++; if (oC !== 5'd2) begin errors++; $display("FAIL start_oC got=%0d exp=2", oC); end
        checks++; if ({oFilterResetN, oProcessing, oBusy} !== 3'b001) begin
            errors++; $display("FAIL arm1_flags got=%b exp=001", {oFilterResetN, oProcessing, oBusy}); end
        step();
        checks++; if ({oFilterResetN, oProcessing, oBusy} !== 3'b001) begin
            errors++; $display("FAIL arm2_flags got=%b exp=001", {oFilterResetN, oProcessing, oBusy}); end
        step();
        checks++; if ({oFilterResetN, oProcessing, oBusy} !== 3'b111) begin
            errors++; $display("FAIL run_flags got=%b exp=111", {oFilterResetN, oProcessing, oBusy}); end
    endtask

    task automatic test_run();
        repeat (50) step();
        checks++; if (oRunCycles !== 24'd50) begin errors++; $display("FAIL run_mid_count got=%0d exp=50", oRunCycles); end
        repeat (49) step();
        iFinished = 1'b1;
        step();
        iFinished = 1'b0;
        checks++; if (oRunCycles !== 24'd100) begin errors++; $display("FAIL run_count got=%0d exp=100", oRunCycles); end
        checks++; if ({oProcessing, oBusy, oDone} !== 3'b010) begin
            errors++; $display("FAIL drain1_flags got=%b exp=010", {oProcessing, oBusy, oDone}); end
        step();
        checks++; if ({oProcessing, oBusy, oDone} !== 3'b010) begin
            errors++; $display("FAIL drain2_flags got=%b exp=010", {oProcessing, oBusy, oDone}); end
        step();
        checks++; if ({oBusy, oDone, oFilterResetN, oProcessing} !== 4'b0110) begin
            errors++; $display("FAIL done_flags got=%b exp=0110", {oBusy, oDone, oFilterResetN, oProcessing}); end
        checks++; if (oRunCycles !== 24'd100) begin errors++; $display("FAIL done_count got=%0d exp=100", oRunCycles); end
    endtask

    task automatic test_arbiter();
        iDispReq = 1'b1; iDispCol = 8'd5; iDispRow = 8'd7;
        iHostReq = 1'b1; iHostCol = 8'd9; iHostRow = 8'd9;
        #1;
        checks++; if ({oDispGrant, oHostGrant, oRdCol, oRdRow} !== {2'b10, 8'd5, 8'd7}) begin
            errors++; $display("FAIL arb_disp got=%b,%0d,%0d exp=10,5,7", {oDispGrant, oHostGrant}, oRdCol, oRdRow); end
        iDispReq = 1'b0;
        #1;
        checks++; if ({oDispGrant, oHostGrant, oRdCol, oRdRow} !== {2'b01, 8'd9, 8'd9}) begin
            errors++; $display("FAIL arb_host got=%b,%0d,%0d exp=01,9,9", {oDispGrant, oHostGrant}, oRdCol, oRdRow); end
        iHostReq = 1'b0;
        #1;
        checks++; if ({oDispGrant, oHostGrant, oRdCol, oRdRow} !== 18'd0) begin
            errors++; $display("FAIL arb_none got=%h exp=0", {oDispGrant, oHostGrant, oRdCol, oRdRow}); end
        iHostReq = 1'b1; iDispReq = 1'b1; iStart = 1'b1; iC = 5'd17;
        step();
        iStart = 1'b0;
        checks++; if ({oDispGrant, oHostGrant, oRdCol, oRdRow} !== 18'd0) begin
            errors++; $display("FAIL arb_arm_drop got=%h exp=0", {oDispGrant, oHostGrant, oRdCol, oRdRow}); end
        checks++; if ({oC, oBusy, oDone, oRunCycles} !== {5'd17, 2'b10, 24'd0}) begin
            errors++; $display("FAIL rearm got=%0d,%b,%0d exp=17,10,0", oC, {oBusy, oDone}, oRunCycles); end
        iDispReq = 1'b0; iHostReq = 1'b0;
    endtask

    task automatic test_ignore_start();
        step(); step();
        iStart = 1'b1; step();
        iStart = 1'b0; step();
        checks++; if ({oProcessing, oBusy, oRunCycles} !== {2'b11, 24'd2}) begin
            errors++; $display("FAIL ignore_run got=%b,%0d exp=11,2", {oProcessing, oBusy}, oRunCycles); end
        iFinished = 1'b1; step();
        iFinished = 1'b0; step(); step();
        checks++; if ({oDone, oBusy, oRunCycles} !== {2'b10, 24'd3}) begin
            errors++; $display("FAIL ignore_done got=%b,%0d exp=10,3", {oDone, oBusy}, oRunCycles); end
        step(); step();
        checks++; if ({oDone, oBusy} !== 2'b10) begin
            errors++; $display("FAIL ignore_not_queued got=%b exp=10", {oDone, oBusy}); end
    endtask

    task automatic test_timeout();
        reset = 1'b1; step(); reset = 1'b0;
        iStart = 1'b1; step();
        iStart = 1'b0; step(); step();
        repeat (15) step();
        checks++; if ({tProcessing, tTimeout, tRunCycles} !== {2'b10, 24'd15}) begin
            errors++; $display("FAIL to_pre got=%b,%0d exp=10,15", {tProcessing, tTimeout}, tRunCycles); end
        step();
        checks++; if ({tTimeout, tFilterResetN, tProcessing, tBusy, tDone} !== 5'b10000) begin
            errors++; $display("FAIL to_error got=%b exp=10000", {tTimeout, tFilterResetN, tProcessing, tBusy, tDone}); end
        checks++; if (tRunCycles !== 24'd16) begin errors++; $display("FAIL to_count got=%0d exp=16", tRunCycles); end
        step();
        checks++; if (tTimeout !== 1'b1) begin errors++; $display("FAIL to_hold got=%b exp=1", tTimeout); end
        iStart = 1'b1; step();
        iStart = 1'b0;
        checks++; if ({tTimeout, tBusy, tFilterResetN, tRunCycles} !== {3'b010, 24'd0}) begin
            errors++; $display("FAIL to_rearm got=%b,%0d exp=010,0", {tTimeout, tBusy, tFilterResetN}, tRunCycles); end
        step(); step();
        repeat (15) step();
        iFinished = 1'b1; step();
        iFinished = 1'b0;
        checks++; if ({tTimeout, tBusy, tProcessing, tRunCycles} !== {3'b010, 24'd16}) begin
            errors++; $display("FAIL to_finish_wins got=%b,%0d exp=010,16", {tTimeout, tBusy, tProcessing}, tRunCycles); end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1; step(); reset = 1'b0;
        iC = 5'd9; iStart = 1'b1; step();
        iStart = 1'b0; step(); step(); step(); step();
        checks++; if ({oProcessing, oRunCycles} !== {1'b1, 24'd2}) begin
            errors++; $display("FAIL mid_pre got=%b,%0d exp=1,2", oProcessing, oRunCycles); end
        reset = 1'b1; iStart = 1'b1; step();
        checks++; if ({oC, oFilterResetN, oProcessing, oBusy, oDone, oTimeout, oRunCycles} !== {5'd0, 5'b10000, 24'd0}) begin
            errors++; $display("FAIL mid_reset got=%0d,%b,%0d exp=0,10000,0", oC, {oFilterResetN, oProcessing, oBusy, oDone, oTimeout}, oRunCycles); end
        reset = 1'b0; step(); step();
        checks++; if ({oBusy, oFilterResetN} !== 2'b01) begin
            errors++; $display("FAIL held_start_no_edge got=%b exp=01", {oBusy, oFilterResetN}); end
        iStart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_run();
        test_arbiter();
        test_ignore_start();
        test_timeout();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
